// File: rtl/cards_pkg.sv
// Shared card types, deck constants and encoding helpers for the dealing shoe.
package cards_pkg;

  localparam int NUM_CARDS = 52;
  localparam int NUM_RANKS = 13;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  typedef enum logic [1:0] {IDLE, SEARCH, DELIVER, CLEAR} shoe_state_t;

  function automatic logic [4:0] rank_to_points(input logic [3:0] rank);
    if (rank == 4'd1)
      return 5'd11;
    else if (rank > 4'd10)
      return 5'd10;
    else
      return {1'b0, rank};
  endfunction

  // Card index 0..51 -> (suit, rank) with a compare/subtract ladder instead of a divider.
  function automatic card_t idx_to_card(input logic [5:0] idx);
    card_t      c;
    logic [5:0] r;
    if (idx >= 6'(3 * NUM_RANKS)) begin
      c.suit = 2'd3;
      r      = idx - 6'(3 * NUM_RANKS);
    end else if (idx >= 6'(2 * NUM_RANKS)) begin
      c.suit = 2'd2;
      r      = idx - 6'(2 * NUM_RANKS);
    end else if (idx >= 6'(NUM_RANKS)) begin
      c.suit = 2'd1;
      r      = idx - 6'(NUM_RANKS);
    end else begin
      c.suit = 2'd0;
      r      = idx;
    end
    c.rank = 4'(r + 6'd1);
    return c;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, reloaded with SEED on reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] state
);

  // NOTE: clocked state always uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst)
      state <= SEED;
    else
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
  end

endmodule

// File: rtl/card_shoe.sv
// 52-card dealing shoe: random start index from an LFSR, linear probe of a
// used-card bitmap, one-cycle valid pulse per delivered card.
module card_shoe
  import cards_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          NUM_CARDS = 52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle,
  input  logic       draw_req,
  output logic       card_valid,
  output logic [1:0] card_suit,
  output logic [3:0] card_rank,
  output logic [4:0] card_points,
  output logic [5:0] cards_left,
  output logic       busy,
  output logic       draw_err
);

  localparam logic [5:0] DECK_SIZE = 6'(NUM_CARDS);
  localparam logic [5:0] LAST_IDX  = 6'(NUM_CARDS - 1);

  logic [15:0]          lfsr;
  logic                 unused_lfsr_bits;
  logic [5:0]           start_idx;
  logic [5:0]           idx;
  logic [NUM_CARDS-1:0] used;
  card_t                pick;
  shoe_state_t          state;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .state (lfsr)
  );

  // Only the low six bits seed the search; fold 52..63 back onto 0..11.
  assign unused_lfsr_bits = ^lfsr[15:6];
  assign start_idx = (lfsr[5:0] >= DECK_SIZE) ? lfsr[5:0] - DECK_SIZE : lfsr[5:0];
  assign pick      = idx_to_card(idx);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      // NOTE: the used bitmap is control state, not storage, so it must be
      // reset; an unknown bitmap would break the no-repeat guarantee.
      used        <= '0;
      idx         <= '0;
      cards_left  <= DECK_SIZE;
      card_valid  <= 1'b0;
      card_suit   <= '0;
      card_rank   <= '0;
      card_points <= '0;
      busy        <= 1'b0;
      draw_err    <= 1'b0;
    end else begin
      card_valid <= 1'b0;
      draw_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (shuffle) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end else if (draw_req) begin
            if (cards_left == '0) begin
              draw_err <= 1'b1;
            end else begin
              idx   <= start_idx;
              state <= SEARCH;
              busy  <= 1'b1;
            end
          end
        end
        SEARCH: begin
          // cards_left > 0 on entry, so a free slot is reached within 52 probes.
          if (!used[idx]) begin
            used[idx]   <= 1'b1;
            cards_left  <= cards_left - 6'd1;
            card_suit   <= pick.suit;
            card_rank   <= pick.rank;
            card_points <= rank_to_points(pick.rank);
            card_valid  <= 1'b1;
            state       <= DELIVER;
          end else begin
            idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
          end
        end
        DELIVER: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        CLEAR: begin
          used       <= '0;
          cards_left <= DECK_SIZE;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Self-checking bench for card_shoe: reference LFSR plus bitmap model, a
// hand-computed vector table and directed multi-cycle corner sequences.
module tb_card_shoe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       shuffle = 1'b0;
  logic       draw_req = 1'b0;
  logic       card_valid;
  logic [1:0] card_suit;
  logic [3:0] card_rank;
  logic [4:0] card_points;
  logic [5:0] cards_left;
  logic       busy;
  logic       draw_err;

  card_shoe #(.LFSR_SEED(16'hACE1), .NUM_CARDS(52)) dut (
    .clk         (clk),
    .rst         (rst),
    .shuffle     (shuffle),
    .draw_req    (draw_req),
    .card_valid  (card_valid),
    .card_suit   (card_suit),
    .card_rank   (card_rank),
    .card_points (card_points),
    .cards_left  (cards_left),
    .busy        (busy),
    .draw_err    (draw_err)
  );

  always #5 clk = ~clk;

  // Reference LFSR: seed on reset, one Fibonacci step (taps 16,14,13,11) per clock.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [51:0] m_used;
  logic [51:0] seen;
  int          m_left;

  int r_cand, r_k, r_suit, r_rank, r_points, r_left;
  bit r_valid, r_err, r_busy0, r_busy_end;

  typedef struct {
    int target;
    int suit;
    int rank;
    int points;
    int left;
    int probes;
  } vec_t;
  vec_t tbl[16];

  function automatic int cand_of(input logic [15:0] s);
    int v;
    v = int'(s[5:0]);
    return (v >= 52) ? v - 52 : v;
  endfunction

  function automatic int points_of(input int rank);
    case (rank)
      1:          return 11;
      11, 12, 13: return 10;
      default:    return rank;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one draw_req (optionally once the shoe's start index equals target)
  // and collect the response; returns one cycle after the pulse, back in IDLE.
  task automatic do_draw(input int target);
    int w = 0;
    if (target >= 0) begin
      while (cand_of(m_lfsr) != target && w < 4000) begin
        @(negedge clk);
        w++;
      end
      check("target_reached", cand_of(m_lfsr), target);
    end
    r_cand   = cand_of(m_lfsr);
    draw_req = 1'b1;
    r_valid  = 1'b0;
    r_err    = 1'b0;
    r_k      = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      draw_req = 1'b0;
      if (k == 0) r_busy0 = busy;
      if (draw_err) r_err = 1'b1;
      if (card_valid) begin
        r_valid  = 1'b1;
        r_k      = k;
        r_suit   = int'(card_suit);
        r_rank   = int'(card_rank);
        r_points = int'(card_points);
        r_left   = int'(cards_left);
        break;
      end
    end
    @(negedge clk);
    r_busy_end = busy;
  endtask

  task automatic model_draw(input string tag);
    int e;
    int u;
    e = r_cand;
    if (m_left > 0)
      while (m_used[e]) e = (e == 51) ? 0 : e + 1;
    check({tag, "_valid"},  r_valid,  1);
    check({tag, "_busy"},   r_busy0,  1);
    check({tag, "_idle"},   r_busy_end, 0);
    check({tag, "_suit"},   r_suit,   e / 13);
    check({tag, "_rank"},   r_rank,   e % 13 + 1);
    check({tag, "_points"}, r_points, points_of(e % 13 + 1));
    check({tag, "_left"},   r_left,   m_left - 1);
    check({tag, "_prange"}, (r_points >= 2 && r_points <= 11), 1);
    u = r_suit * 13 + r_rank - 1;
    check({tag, "_unique"}, (u >= 0 && u < 52) ? seen[u] : 1'b1, 0);
    if (u >= 0 && u < 52) seen[u] = 1'b1;
    m_used[e] = 1'b1;
    m_left--;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    shuffle = 1'b0;
    draw_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_used = '0;
    seen = '0;
    m_left = 52;
  endtask

  task automatic do_shuffle();
    shuffle = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    check("shuffle_busy", busy, 1);
    @(negedge clk);
    check("shuffle_done_busy", busy, 0);
    check("shuffle_left", cards_left, 52);
    m_used = '0;
    seen = '0;
    m_left = 52;
  endtask

  int first_cards[5];
  int cnt;

  initial begin
    tbl[0]  = '{0,  0, 1, 11, 51, 1};
    tbl[1]  = '{12, 0, 13, 10, 50, 1};
    tbl[2]  = '{13, 1, 1, 11, 49, 1};
    tbl[3]  = '{25, 1, 13, 10, 48, 1};
    tbl[4]  = '{26, 2, 1, 11, 47, 1};
    tbl[5]  = '{38, 2, 13, 10, 46, 1};
    tbl[6]  = '{39, 3, 1, 11, 45, 1};
    tbl[7]  = '{51, 3, 13, 10, 44, 1};
    tbl[8]  = '{9,  0, 10, 10, 43, 1};
    tbl[9]  = '{22, 1, 10, 10, 42, 1};
    tbl[10] = '{30, 2, 5, 5, 41, 1};
    tbl[11] = '{44, 3, 6, 6, 40, 1};
    tbl[12] = '{0,  0, 2, 2, 39, 2};
    tbl[13] = '{51, 0, 3, 3, 38, 4};
    tbl[14] = '{11, 0, 12, 10, 37, 1};
    tbl[15] = '{12, 1, 2, 2, 36, 3};

    // Reset values
    do_reset();
    check("rst_valid",  card_valid, 0);
    check("rst_suit",   card_suit, 0);
    check("rst_rank",   card_rank, 0);
    check("rst_points", card_points, 0);
    check("rst_left",   cards_left, 52);
    check("rst_busy",   busy, 0);
    check("rst_err",    draw_err, 0);

    // Full deck, then an empty-shoe draw
    for (int i = 0; i < 52; i++) begin
      do_draw(-1);
      model_draw("deck");
      check("deck_count", r_left, 51 - i);
    end
    do_draw(-1);
    check("empty_err",   r_err, 1);
    check("empty_valid", r_valid, 0);
    check("empty_busy",  r_busy0, 0);
    check("empty_left",  cards_left, 0);

    // Shuffle, 10 draws, then shuffle+draw together: shuffle wins
    do_shuffle();
    for (int i = 0; i < 10; i++) begin
      do_draw(-1);
      model_draw("pre10");
    end
    check("pre10_left", cards_left, 42);
    shuffle = 1'b1;
    draw_req = 1'b1;
    @(negedge clk);
    shuffle = 1'b0;
    draw_req = 1'b0;
    check("prio_busy", busy, 1);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (card_valid || draw_err) cnt++;
    end
    check("prio_no_card", cnt, 0);
    check("prio_left", cards_left, 52);
    check("prio_idle", busy, 0);
    m_used = '0;
    seen = '0;
    m_left = 52;
    for (int i = 0; i < 52; i++) begin
      do_draw(-1);
      model_draw("redeal");
    end
    check("redeal_left", cards_left, 0);

    // draw_req held into SEARCH is dropped: exactly one card
    do_shuffle();
    draw_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    draw_req = 1'b0;
    cnt = card_valid ? 1 : 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (card_valid) cnt++;
    end
    check("search_drop_count", cnt, 1);
    check("search_drop_left", cards_left, 51);

    // Hand-computed vectors: targeted start index, including probe chains and wrap
    do_shuffle();
    foreach (tbl[i]) begin
      do_draw(tbl[i].target);
      check("vec_valid",  r_valid,  1);
      check("vec_suit",   r_suit,   tbl[i].suit);
      check("vec_rank",   r_rank,   tbl[i].rank);
      check("vec_points", r_points, tbl[i].points);
      check("vec_left",   r_left,   tbl[i].left);
      check("vec_probes", r_k,      tbl[i].probes);
    end

    // Wrap-around: only index 0 free, start at 51
    do_shuffle();
    for (int t = 1; t < 52; t++) begin
      do_draw(t);
      model_draw("fill");
    end
    do_draw(51);
    check("wrap_valid",  r_valid, 1);
    check("wrap_suit",   r_suit, 0);
    check("wrap_rank",   r_rank, 1);
    check("wrap_points", r_points, 11);
    check("wrap_probes", r_k, 2);
    check("wrap_left",   r_left, 0);

    // Determinism across resets
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_draw(-1);
      model_draw("det_a");
      first_cards[i] = r_suit * 16 + r_rank;
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_draw(-1);
      model_draw("det_b");
      check("det_same", r_suit * 16 + r_rank, first_cards[i]);
    end

    // Reset asserted during SEARCH aborts the draw
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    check("midrst_searching", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cnt = card_valid ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (card_valid) cnt++;
    end
    check("midrst_no_card", cnt, 0);
    check("midrst_left", cards_left, 52);
    check("midrst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
